// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream programmer for the instruction memory
module imem_loader #(
  parameter int          MEM_BYTES = 128,
  parameter int          ADDR_W    = 7,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  // Largest legal word count; 9 bits so the LEN byte compares without truncation.
  localparam logic [8:0] MAX_WORDS = 9'(MEM_BYTES / 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_VERIFY,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_next;

  // ready_q is low only while reset is held and goes high on the first edge after release.
  logic       ready_q;
  // byte_cnt counts data bytes of the current frame and doubles as the write address.
  logic [8:0] byte_cnt;
  logic [8:0] byte_total;
  logic [7:0] acc;
  logic [7:0] chk;

  logic accept;
  logic start_frame;
  logic len_ok;
  logic len_bad;
  logic data_byte;
  logic chk_byte;
  logic verify_pass;
  logic verify_fail;

  // The single VERIFY cycle refuses input so the checksum compare sees a stable accumulator.
  assign in_ready = ready_q & (state != S_VERIFY);
  assign accept   = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; also produces one-cycle action strobes for the datapath.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    len_ok      = 1'b0;
    len_bad     = 1'b0;
    data_byte   = 1'b0;
    chk_byte    = 1'b0;
    verify_pass = 1'b0;
    verify_fail = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        // Anything other than the sync marker between frames is discarded.
        if (accept && (in_data == SYNC_BYTE)) begin
          start_frame = 1'b1;
          state_next  = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          if ((in_data == 8'd0) || ({1'b0, in_data} > MAX_WORDS)) begin
            len_bad    = 1'b1;
            state_next = S_ERR;
          end else begin
            len_ok     = 1'b1;
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        // Once every data byte has been counted the next byte is the checksum.
        if (accept) begin
          if (byte_cnt == byte_total) begin
            chk_byte   = 1'b1;
            state_next = S_VERIFY;
          end else begin
            data_byte  = 1'b1;
          end
        end
      end
      S_VERIFY: begin
        if (chk == acc) begin
          verify_pass = 1'b1;
          state_next  = S_DONE;
        end else begin
          verify_fail = 1'b1;
          state_next  = S_ERR;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: frame bookkeeping, registered memory write port and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q    <= 1'b0;
      byte_cnt   <= 9'd0;
      byte_total <= 9'd0;
      acc        <= 8'd0;
      chk        <= 8'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'd0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      mem_we  <= 1'b0;
      if (start_frame) begin
        load_done  <= 1'b0;
        load_error <= 1'b0;
        acc        <= 8'd0;
        byte_cnt   <= 9'd0;
        cpu_hold   <= 1'b1;
      end
      if (len_ok) begin
        byte_total <= {in_data[6:0], 2'b00};
      end
      if (len_bad) begin
        load_error <= 1'b1;
      end
      if (data_byte) begin
        mem_we    <= 1'b1;
        mem_addr  <= byte_cnt[ADDR_W-1:0];
        mem_wdata <= in_data;
        acc       <= acc ^ in_data;
        byte_cnt  <= byte_cnt + 9'd1;
      end
      if (chk_byte) begin
        chk <= in_data;
      end
      if (verify_pass) begin
        load_done <= 1'b1;
        cpu_hold  <= 1'b0;
      end
      if (verify_fail) begin
        load_error <= 1'b1;
      end
    end
  end

endmodule
